spi_master: RTL
===============

# spi_master

Byte-oriented SPI master that drives the four-wire link into the `spiMemory` slave. It accepts one read or write request from a host-side controller and serialises a 16-bit frame: a command byte {addr[6:0], rw}, then a data byte. On reads it captures the slave's data byte and returns it on `rdata`. It sits directly upstream of `spiMemory` and drives its `sclk_pin`, `cs_pin` and `mosi_pin`, and samples its `miso_pin`.

## Interface
- `CLK_DIV`, default 8: half-period of `sclk` in `clk` cycles. Legal range 4..255, so the slave's input conditioners settle inside each phase.
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `start`, input, 1: request strobe. Accepted only on a rising `clk` edge where `busy`=0.
- `rw`, input, 1: 1 = read, 0 = write. Captured at acceptance.
- `addr`, input, 7: memory address. Captured at acceptance.
- `wdata`, input, 8: write data. Captured at acceptance; ignored for reads.
- `busy`, output, 1: high from the cycle after acceptance until the inter-frame gap ends.
- `done`, output, 1: one-cycle pulse at end of frame.
- `rdata`, output, 8: last read byte. Updated only on read frames, valid when `done`=1.
- `sclk`, output, 1: serial clock, idle low (mode 0).
- `cs`, output, 1: chip select, active low.
- `mosi`, output, 1: serial data out, MSB first.
- `miso`, input, 1: serial data in from slave.

## Operation
- Reset values: `sclk`=0, `cs`=1, `mosi`=0, `busy`=0, `done`=0, `rdata`=0x00, state IDLE.
- On acceptance, load a 16-bit tx shift register with {addr, rw, wdata}. For reads, the low byte is 0x00.
- States and transitions:
  - IDLE: `cs`=1, `sclk`=0. Goes to LEAD on `start`.
  - LEAD: `cs`=0, `mosi`=tx[15]. Lasts CLK_DIV cycles.
  - HIGH: `sclk`=1 for CLK_DIV cycles. On the last cycle, shift `miso` into the rx register.
  - LOW: `sclk`=0 for CLK_DIV cycles. On entry, shift tx left, so `mosi` changes only on the falling `sclk` edge. After the 16th LOW, go to GAP; otherwise go back to HIGH.
  - GAP: `cs`=1, `done`=1 on the first cycle, lasts 2*CLK_DIV cycles, then IDLE.
- Counters:
  - Divider counter: 8 bits, reloads at every state change.
  - Bit counter: 4 bits, counts 0..15 and wraps to 0 in GAP.
- rx captures all 16 bits. On read frames, `rdata` <= rx[7:0] on the GAP entry cycle. The command-phase bits are discarded.
- `start` is ignored while `busy`=1, including on the `done` cycle. Inputs are sampled only at acceptance, so later changes have no effect on a frame in flight.
- Reset mid-frame: `cs` goes to 1 and `sclk` to 0 immediately (asynchronous). No `done` pulse. The partial frame is lost and `rdata` returns to 0x00.

## Timing
- Acceptance cycle T: `busy`, `cs`=0 and `mosi`=bit15 are all visible at T+1.
- First `sclk` rise: T+1+CLK_DIV.
- `cs` low duration: 33*CLK_DIV cycles, giving 16 rising `sclk` edges.
- `done` and `cs`=1 at T+1+33*CLK_DIV.
- `busy` falls at T+1+35*CLK_DIV. The earliest next acceptance is that cycle.
- With CLK_DIV=8: 264-cycle `cs`-low window and 281 cycles from acceptance to `busy` low.

## Structure
- Shared header `spi_defs.v` holds:
  - `RW_READ`=1 and `RW_WRITE`=0
  - frame length 16
  - state encodings for IDLE/LEAD/HIGH/LOW/GAP
  
  `spiMemory`-side code reuses the RW constants.
- One natural sub-module, `sclk_divider`: a loadable down-counter producing a one-cycle `phase_end` pulse after CLK_DIV cycles, reloaded by the FSM.
- The tx/rx shift registers stay inline. The FSM is a single always block with an asynchronous `reset` branch.

## Test plan
- Reset: hold `reset` 3 cycles mid-stream, then release → all outputs at reset values and `busy`=0 the first cycle after release.
- Write, CLK_DIV=4, addr=0x2A, wdata=0xC3, rw=0 → `mosi` bits at `sclk` rises = 0x54 then 0xC3 MSB first, exactly 16 rises, `cs` low 132 cycles, single `done`, `rdata` stays 0x00.
- Read, addr=0x2A, rw=1, miso model driving 0xC3 in the data phase → command 0x55 on `mosi`, data-phase `mosi`=0, `rdata`=0xC3 on the `done` cycle.
- `start` pulsed at T+1 and T+50 during a frame → only one frame, one `done`. Then `start` held high → second frame accepted exactly when `busy` falls, with `cs` high for 2*CLK_DIV cycles between frames.
- Asynchronous reset asserted between `clk` edges during bit 7 → `cs`=1 and `sclk`=0 without waiting for `clk`, no `done`. Next read of 0x01 then completes normally.
- Integration with a `spiMemory` instance: write 0x5A to 0x10, write 0xA5 to 0x11, read 0x10 → `rdata`=0x5A; read 0x11 → `rdata`=0xA5.

Source files
------------

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared frame constants and FSM encoding for the SPI master
package spi_master_pkg;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam int FRAME_LEN = 16;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;
endpackage

// File: rtl/spi_master_sclk_divider.sv
// sclk_divider: loadable down-counter flagging the last cycle of each sclk phase
module sclk_divider #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic phase_end
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
    logic [7:0] cnt_q, cnt_d;
    // reload on request, otherwise count down and park at zero
    always_comb cnt_d = load ? RELOAD : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
    // divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
    assign phase_end = (cnt_q == 8'd0);
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master sending {addr, rw, wdata} and returning the read byte
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    state_t      state_q, state_d;
    logic [15:0] tx_q, tx_d, rx_q, rx_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        gap_half_q, gap_half_d, rw_q, rw_d;
    logic        sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        load, phase_end;

    sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .phase_end (phase_end)
    );

    // next-state and registered-output logic; every phase change reloads the divider
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        rdata_d    = rdata_q;
        gap_half_d = gap_half_q;
        rw_d       = rw_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LEAD;
                tx_d    = {addr, rw, (rw == RW_WRITE) ? wdata : 8'h00};
                rw_d    = rw;
                cs_d    = 1'b0;
                mosi_d  = addr[6];
                busy_d  = 1'b1;
                load    = 1'b1;
            end
            LEAD: if (phase_end) begin
                state_d = HIGH;
                sclk_d  = 1'b1;
                load    = 1'b1;
            end
            HIGH: if (phase_end) begin
                state_d = LOW;
                rx_d    = {rx_q[14:0], miso};
                tx_d    = {tx_q[14:0], 1'b0};
                mosi_d  = tx_q[14];
                sclk_d  = 1'b0;
                load    = 1'b1;
            end
            LOW: if (phase_end) begin
                load = 1'b1;
                if (bit_q == LAST_BIT) begin
                    state_d    = GAP;
                    bit_d      = 4'd0;
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    done_d     = 1'b1;
                    gap_half_d = 1'b0;
                    rdata_d    = (rw_q == RW_READ) ? rx_q[7:0] : rdata_q;
                end else begin
                    state_d = HIGH;
                    bit_d   = bit_q + 4'd1;
                    sclk_d  = 1'b1;
                end
            end
            GAP: if (phase_end) begin
                load       = 1'b1;
                gap_half_d = 1'b1;
                state_d    = gap_half_q ? IDLE : GAP;
                busy_d     = ~gap_half_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset forces the link idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_q       <= 16'h0000;
            rx_q       <= 16'h0000;
            bit_q      <= 4'd0;
            rdata_q    <= 8'h00;
            gap_half_q <= 1'b0;
            rw_q       <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            rdata_q    <= rdata_d;
            gap_half_q <= gap_half_d;
            rw_q       <= rw_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;
endmodule
